// File: rtl/barrett_precomp_if.sv
// Shared datapath width plus the request/result bundle between the Barrett
// precompute unit and its host.
package multiplier_pkg;
    localparam int unsigned DATA_LENGTH = 64;
endpackage

interface barrett_precomp_if;
    logic                                  start_i;
    logic [multiplier_pkg::DATA_LENGTH-1:0] m_i;
    logic                                  busy_o;
    logic                                  valid_o;
    logic                                  ready_i;
    logic [multiplier_pkg::DATA_LENGTH-1:0] mu_o;
    logic [multiplier_pkg::DATA_LENGTH-1:0] m_bl_o;
    logic                                  error_o;

    modport slave (
        input  start_i, m_i, ready_i,
        output busy_o, valid_o, mu_o, m_bl_o, error_o
    );

    modport master (
        output start_i, m_i, ready_i,
        input  busy_o, valid_o, mu_o, m_bl_o, error_o
    );
endinterface

// File: rtl/barrett_precomp.sv
// Barrett constant precompute: bit length k of m and mu = floor(2^(2k)/m)
// by restoring division, one quotient bit per cycle.
module barrett_precomp
    import multiplier_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    barrett_precomp_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(2 * DATA_LENGTH);
    localparam int unsigned R_W   = DATA_LENGTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        BITLEN,
        DIVIDE,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_LENGTH-1:0] m_q, m_d;
    logic [R_W-1:0]         r_q, r_d;
    logic [DATA_LENGTH-1:0] q_q, q_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       two_k_q, two_k_d;
    logic                   err_q, err_d;
    logic [DATA_LENGTH-1:0] mu_q, mu_d;
    logic [DATA_LENGTH-1:0] m_bl_q, m_bl_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;

    logic [CNT_W-1:0]       k_c;
    logic                   out_of_range_c;
    logic [R_W:0]           r_shift_c;
    logic                   ge_c;
    logic [R_W-1:0]         r_step_c;
    logic [DATA_LENGTH-1:0] q_step_c;

    // Bit length (highest set bit wins) and range check on the captured modulus
    always_comb begin
        k_c = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (m_q[i]) k_c = CNT_W'(i + 1);
        end
        out_of_range_c = (m_q < DATA_LENGTH'(2)) || (m_q[DATA_LENGTH-1 -: 2] != 2'b00);
    end

    // One restoring-division step; the dividend 2^(2k) has its only set bit at i == 2k
    always_comb begin
        r_shift_c = {r_q, (cnt_q == two_k_q)};
        ge_c      = r_shift_c >= {2'b00, m_q};
        r_step_c  = ge_c ? R_W'(r_shift_c - {2'b00, m_q}) : R_W'(r_shift_c);
        q_step_c  = {q_q[DATA_LENGTH-2:0], ge_c};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        two_k_d = two_k_q;
        err_d   = err_q;
        mu_d    = mu_q;
        m_bl_d  = m_bl_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    m_d     = bus.m_i;
                    state_d = BITLEN;
                end
            end
            BITLEN: begin
                r_d     = '0;
                q_d     = '0;
                state_d = DIVIDE;
                if (out_of_range_c) begin
                    err_d  = 1'b1;
                    mu_d   = '0;
                    m_bl_d = '0;
                    cnt_d  = '0;
                end else begin
                    err_d   = 1'b0;
                    m_bl_d  = DATA_LENGTH'(k_c);
                    two_k_d = k_c << 1;
                    cnt_d   = k_c << 1;
                end
            end
            DIVIDE: begin
                // An errored request spends one idle cycle here so its latency is fixed
                if (err_q) begin
                    state_d = DONE;
                end else begin
                    r_d = r_step_c;
                    q_d = q_step_c;
                    if (cnt_q == '0) begin
                        mu_d    = q_step_c;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (valid_q && bus.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            m_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            two_k_q <= '0;
            err_q   <= 1'b0;
            mu_q    <= '0;
            m_bl_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            two_k_q <= two_k_d;
            err_q   <= err_d;
            mu_q    <= mu_d;
            m_bl_q  <= m_bl_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.valid_o = valid_q;
    assign bus.mu_o    = mu_q;
    assign bus.m_bl_o  = m_bl_q;
    assign bus.error_o = err_q;

endmodule

// File: tb/tb_barrett_precomp.sv
// Self-checking bench for barrett_precomp: directed table, handshake and reset
// corner cases, and random moduli against an arithmetic reference.
module tb_barrett_precomp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    barrett_precomp_if bus ();

    barrett_precomp dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [63:0] m;
        logic [63:0] mu;
        logic [63:0] bl;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // mu = floor(2^(2k)/m) straight from the definition, in 128-bit arithmetic
    function automatic void ref_model(input logic [63:0] m, output logic [63:0] mu,
                                      output logic [63:0] bl, output logic err);
        int k;
        logic [127:0] num;
        if (m < 64'd2 || m >= (64'd1 << 62)) begin
            mu = '0; bl = '0; err = 1'b1;
        end else begin
            k = 0;
            while ((m >> k) != 64'd0) k++;
            num = 128'd1 << (2 * k);
            mu  = 64'(num / {64'd0, m});
            bl  = 64'(k);
            err = 1'b0;
        end
    endfunction

    // Barrett reduction of x = m^2-1 using the produced constants
    task automatic check_reduce(input string tag, input logic [63:0] m,
                                input logic [63:0] mu, input int k);
        logic [127:0] x, q, r;
        x = {64'd0, m} * {64'd0, m} - 128'd1;
        q = ((x >> (k - 1)) * {64'd0, mu}) >> (k + 1);
        r = x - q * {64'd0, m};
        for (int c = 0; c < 2; c++) if (r >= {64'd0, m}) r = r - {64'd0, m};
        chk({tag, " reduce"}, r, x % {64'd0, m});
    endtask

    task automatic launch(input logic [63:0] m, output int lat, output bit busy_ok);
        @(negedge clk);
        bus.m_i     = m;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.m_i     = ~m;
        lat     = 0;
        busy_ok = 1'b1;
        while (lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (!bus.busy_o) busy_ok = 1'b0;
            if (bus.valid_o) break;
        end
        if (!bus.valid_o) lat = -1;
    endtask

    task automatic run_vec(input string tag, input logic [63:0] m, input logic [63:0] mu,
                           input logic [63:0] bl, input logic err, input int exp_lat);
        int lat;
        bit busy_ok;
        launch(m, lat, busy_ok);
        chk({tag, " latency"}, 128'(lat), 128'(exp_lat));
        chk({tag, " busy"}, 128'(busy_ok), 128'd1);
        chk({tag, " mu"}, 128'(bus.mu_o), 128'(mu));
        chk({tag, " m_bl"}, 128'(bus.m_bl_o), 128'(bl));
        chk({tag, " error"}, 128'(bus.error_o), 128'(err));
        @(posedge clk);
        #1;
        chk({tag, " valid one cycle"}, 128'(bus.valid_o), 128'd0);
        chk({tag, " idle"}, 128'(bus.busy_o), 128'd0);
        chk({tag, " mu held"}, 128'(bus.mu_o), 128'(mu));
        if (!err) check_reduce(tag, m, bus.mu_o, int'(bl));
    endtask

    initial begin
        int lat;
        bit busy_ok;
        logic [63:0] m, mu, bl;
        logic err;
        int k;

        tbl[0] = '{64'd3,                 64'd5,                    64'd2,  1'b0, 6};
        tbl[1] = '{64'd3329,              64'd5039,                 64'd12, 1'b0, 26};
        tbl[2] = '{64'd7681,              64'd8736,                 64'd13, 1'b0, 28};
        tbl[3] = '{64'h2000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd62, 1'b0, 126};
        tbl[4] = '{64'd1,                 64'd0,                    64'd0,  1'b1, 2};
        tbl[5] = '{64'd0,                 64'd0,                    64'd0,  1'b1, 2};
        tbl[6] = '{64'h4000_0000_0000_0000, 64'd0,                  64'd0,  1'b1, 2};
        tbl[7] = '{64'd5,                 64'd12,                   64'd3,  1'b0, 8};
        tbl[8] = '{64'h3FFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0001, 64'd62, 1'b0, 126};
        tbl[9] = '{64'd2,                 64'd8,                    64'd2,  1'b0, 6};

        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        bus.m_i     = '0;
        bus.ready_i = 1'b1;
        #23;
        chk("reset busy", 128'(bus.busy_o), 128'd0);
        chk("reset valid", 128'(bus.valid_o), 128'd0);
        chk("reset error", 128'(bus.error_o), 128'd0);
        chk("reset mu", 128'(bus.mu_o), 128'd0);
        chk("reset m_bl", 128'(bus.m_bl_o), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_vec($sformatf("tbl%0d", i), tbl[i].m, tbl[i].mu, tbl[i].bl, tbl[i].err, tbl[i].lat);

        // Back-pressure: result held, stray start ignored
        bus.ready_i = 1'b0;
        launch(64'd3329, lat, busy_ok);
        chk("bp latency", 128'(lat), 128'd26);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus.m_i     = 64'd5;
                bus.start_i = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.start_i = 1'b0;
            chk("bp valid", 128'(bus.valid_o), 128'd1);
            chk("bp busy", 128'(bus.busy_o), 128'd1);
            chk("bp mu", 128'(bus.mu_o), 128'd5039);
            chk("bp m_bl", 128'(bus.m_bl_o), 128'd12);
        end
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        chk("bp release valid", 128'(bus.valid_o), 128'd0);
        chk("bp release busy", 128'(bus.busy_o), 128'd0);
        @(posedge clk);
        #1;
        chk("bp no queued start", 128'(bus.busy_o), 128'd0);
        run_vec("bp next", 64'd5, 64'd12, 64'd3, 1'b0, 8);

        // Reset in the middle of a division
        @(negedge clk);
        bus.m_i     = 64'd7681;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("mid busy", 128'(bus.busy_o), 128'd1);
        chk("mid m_bl", 128'(bus.m_bl_o), 128'd13);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 128'(bus.busy_o), 128'd0);
        chk("abort valid", 128'(bus.valid_o), 128'd0);
        chk("abort mu", 128'(bus.mu_o), 128'd0);
        chk("abort m_bl", 128'(bus.m_bl_o), 128'd0);
        chk("abort error", 128'(bus.error_o), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort no output", 128'(bus.valid_o), 128'd0);
        run_vec("after abort", 64'd3, 64'd5, 64'd2, 1'b0, 6);

        // Random in-range moduli of every bit length, then random out-of-range ones
        for (int n = 0; n < 40; n++) begin
            k = int'($urandom_range(2, 62));
            m = {$urandom, $urandom};
            m = (m & ((64'd1 << k) - 64'd1)) | (64'd1 << (k - 1));
            ref_model(m, mu, bl, err);
            run_vec($sformatf("rnd%0d", n), m, mu, bl, err, err ? 2 : 2 * int'(bl) + 2);
        end
        for (int n = 0; n < 6; n++) begin
            if (n < 2) m = 64'($urandom_range(0, 1));
            else       m = {$urandom, $urandom} | (64'd1 << $urandom_range(62, 63));
            ref_model(m, mu, bl, err);
            run_vec($sformatf("rnd_err%0d", n), m, mu, bl, err, err ? 2 : 2 * int'(bl) + 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/barrett_precomp.md
Name: barrett_precomp

Overview:
- Sequential precompute unit producing the constants the bit-parallel Barrett reducer consumes: bit length k of modulus m (m_bl) and mu = floor(2^(2k) / m).
- Iterative restoring division, one quotient bit per cycle.
- Sits ahead of the reducer and is run once per modulus change. Outputs are held under a valid/ready handshake until taken.

Parameters:
- DATA_LENGTH, 64 (from multiplier_pkg, not overridden locally), datapath width of m, mu and m_bl.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- m_i  input  DATA_LENGTH  modulus; captured on the edge that accepts start_i.
- busy_o  output  1  high in every state except IDLE.
- valid_o  output  1  result/error available.
- ready_i  input  1  consumer accepts result when valid_o && ready_i.
- mu_o  output  DATA_LENGTH  floor(2^(2k)/m).
- m_bl_o  output  DATA_LENGTH  k = index of highest set bit of m, plus 1.
- error_o  output  1  modulus out of range; qualified by valid_o.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - busy_o=0, valid_o=0, error_o=0, mu_o=0, m_bl_o=0.
  - Internal remainder, quotient and counter cleared.
  - An aborted computation produces no output.
- IDLE:
  - start_i=1 captures m_i into m_q and moves to BITLEN.
  - start_i is ignored in all other states; there is no queuing.
- BITLEN (1 cycle):
  - k = position of the MSB of m_q, plus 1.
  - Valid range is 2 <= m_q < 2^(DATA_LENGTH-2), so k is 2..62 and mu <= 2^(k+1) <= 2^63 fits in DATA_LENGTH.
  - Out of range (m_q < 2 or m_q >= 2^(DATA_LENGTH-2)): go to DONE with error_o=1, mu_o=0, m_bl_o=0.
  - In range: m_bl_o=k, counter=2k, remainder r=0, quotient q=0; go to DIVIDE.
- DIVIDE (2k+1 cycles, counter i from 2k down to 0):
  - Dividend bit d_i = (i == 2k).
  - r' = (r<<1) | d_i. If r' >= m_q then r = r' - m_q and q = (q<<1)|1; else r = r' and q = q<<1.
  - r is DATA_LENGTH+1 bits wide, with no truncation; r < m_q invariant.
  - The i==0 iteration writes mu_o=q_final, then moves to DONE.
- DONE:
  - valid_o=1. mu_o, m_bl_o and error_o are stable.
  - On valid_o && ready_i: valid_o drops on the same edge and state returns to IDLE.
  - mu_o and m_bl_o keep their last values until the next computation writes them.
  - A start_i in the same cycle as the handshake is ignored.
- Latency:
  - Start sampled at edge E gives valid_o high after edge E+2k+2.
  - Error path: valid_o high after edge E+2.
- Outputs are registered; no combinational path from any input to any output.

Test Plan:
- Reset, then m_i=3, start_i=1, ready_i=1 -> m_bl_o=2, mu_o=5, error_o=0; valid_o rises 6 edges after the start edge and stays high exactly 1 cycle.
- m_i=3329 -> m_bl_o=12, mu_o=5039. m_i=7681 -> m_bl_o=13, mu_o=8736. Cross-check each against a reference model and by feeding into the reducer: x=m^2-1 gives result x mod m.
- m_i=2^61 -> m_bl_o=62, mu_o=0x8000_0000_0000_0000; valid_o after 126 edges; busy_o high throughout.
- m_i=1, m_i=0 and m_i=2^62 -> error_o=1, valid_o after 2 edges, mu_o=0, m_bl_o=0.
- Back-pressure: ready_i=0 for 10 cycles after valid_o -> outputs stable, busy_o=1; start_i pulsed meanwhile is ignored. ready_i=1 -> return to IDLE, next start (m_i=5) gives mu_o=12, m_bl_o=3.
- rst_ni low mid-DIVIDE (m_i=7681, 10 cycles in) -> all outputs 0 immediately. After release, a new start with m_i=3 gives mu_o=5 with nominal latency.
